param_step_counter: RTL and testbench
=====================================

Name: param_step_counter

Overview:
Signed up/down step counter, generalised successor of the fixed-step counter. Width, reset value, bounds, forbidden value and the up/down step sizes are all parameters. Adds count enable, synchronous parallel load with range checking, and registered status flags. Used as a bounded position/credit counter in datapath control, and as a formal-verification target with a bound assertion module.

Parameters:
WIDTH, 10, counter width in bits (two's complement signed)
RST_VAL, 17, value loaded on reset
MAX_VAL, 269, upper bound (inclusive)
MIN_VAL, -263, lower bound (inclusive)
INV_VAL, -47, forbidden value; never appears on cnt
UP_STEP, 4, increment when counting up (>0)
DN_STEP, 10, decrement when counting down (>0)
Legal set: MIN_VAL < INV_VAL < MAX_VAL; MIN_VAL <= RST_VAL <= MAX_VAL; RST_VAL != INV_VAL; all values fit in WIDTH signed. Elaboration-time check; violation is a fatal error.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-low (asserted when 0)
en  in  1  count enable
mode  in  1  1 = count up by UP_STEP, 0 = count down by DN_STEP
load  in  1  parallel load request
load_val  in  WIDTH signed  value to load
cnt  out  WIDTH signed  counter value (registered)
at_max  out  1  registered; 1 when cnt + UP_STEP (after INV skip) would exceed MAX_VAL
at_min  out  1  registered; 1 when cnt - DN_STEP (after INV skip) would fall below MIN_VAL
blocked  out  1  one-cycle pulse: the previous enabled step was suppressed at a bound
load_err  out  1  one-cycle pulse: the previous load was rejected

Behaviour:
- Priority per edge: rst (0) > load > en > hold.
- Reset (rst=0 at edge): cnt=RST_VAL, blocked=0, load_err=0; at_max/at_min recomputed from RST_VAL. Reset mid-operation discards any pending load/step in that cycle.
- Load (load=1): accepted iff MIN_VAL <= load_val <= MAX_VAL and load_val != INV_VAL; on accept, cnt=load_val next cycle. On reject, cnt holds and load_err=1 for one cycle. en is ignored in any load cycle.
- Step (en=1, load=0): cand = cnt ± step, computed at WIDTH+2 bits (no overflow). If cand == INV_VAL, cand = cnt ± 2*step (skip over forbidden value). If cand > MAX_VAL (up) or < MIN_VAL (down), cnt holds and blocked=1 for one cycle; otherwise cnt=cand.
- Hold (en=0, load=0): cnt unchanged, pulses low.
- Latency: 1 cycle from sampled inputs to cnt and all flags.
- at_max/at_min are derived from the registered next cnt value, so they are valid in the same cycle as cnt.
- Invariant: MIN_VAL <= cnt <= MAX_VAL and cnt != INV_VAL at all times after reset.

Optional Feature:
Macro PARAM_STEP_COUNTER_WRAP_EN.
- Defined: an up step beyond MAX_VAL loads MIN_VAL and a down step below MIN_VAL loads MAX_VAL. No remainder is carried. blocked still pulses to flag the wrap event. at_max/at_min keep the same meaning and report that the next step will wrap.
- Undefined: saturate-by-hold as described above. Wrap logic is not elaborated.

Test Plan:
- rst=0 one cycle, then rst=1, en=0 -> cnt=17, at_max=0, at_min=0, blocked=0, load_err=0.
- From 17, en=1 mode=1 for 63 cycles -> cnt reaches 269, at_max=1; next up step -> cnt stays 269, blocked=1 for one cycle (wrap build: cnt=-263).
- load -51, then en=1 mode=1 -> cnt=-43 (skips -47). load -37, then mode=0 -> cnt=-57.
- load -260, then mode=0 -> cnt stays -260, blocked=1, at_min=1 (wrap build: cnt=269).
- load 300, then load -47, then load 0 -> cnt unchanged with load_err pulse after each of the first two loads; cnt=0 after the third with load_err=0.
- load=1 and en=1 in the same cycle with load_val=100 -> cnt=100 (load wins). rst=0 asserted together with load=1 -> cnt=17.

Source files
------------

// File: rtl/param_step_counter_if.sv
// Handshake bundle for param_step_counter: control/load inputs and the
// registered counter value with its status flags.
interface param_step_counter_if #(
  parameter int WIDTH = 10
) ();
  logic                    en;
  logic                    mode;
  logic                    load;
  logic signed [WIDTH-1:0] load_val;
  logic signed [WIDTH-1:0] cnt;
  logic                    at_max;
  logic                    at_min;
  logic                    blocked;
  logic                    load_err;

  modport master (
    output en, mode, load, load_val,
    input  cnt, at_max, at_min, blocked, load_err
  );

  modport slave (
    input  en, mode, load, load_val,
    output cnt, at_max, at_min, blocked, load_err
  );
endinterface

// File: rtl/param_step_counter.sv
// Bounded signed up/down step counter with a forbidden value, range-checked load
// and registered status flags. Define PARAM_STEP_COUNTER_WRAP_EN to wrap at the bounds.
module param_step_counter #(
  parameter int WIDTH   = 10,
  parameter int RST_VAL = 17,
  parameter int MAX_VAL = 269,
  parameter int MIN_VAL = -263,
  parameter int INV_VAL = -47,
  parameter int UP_STEP = 4,
  parameter int DN_STEP = 10
) (
  input logic                 clk,
  input logic                 rst,
  param_step_counter_if.slave bus
);

  // Two guard bits keep cnt +/- 2*step free of overflow.
  localparam int EW = WIDTH + 2;

  localparam logic signed [EW-1:0]    MAX_E = EW'(MAX_VAL);
  localparam logic signed [EW-1:0]    MIN_E = EW'(MIN_VAL);
  localparam logic signed [EW-1:0]    INV_E = EW'(INV_VAL);
  localparam logic signed [EW-1:0]    UP_E  = EW'(UP_STEP);
  localparam logic signed [EW-1:0]    DN_E  = EW'(DN_STEP);
  localparam logic signed [EW-1:0]    UP2_E = EW'(2 * UP_STEP);
  localparam logic signed [EW-1:0]    DN2_E = EW'(2 * DN_STEP);
  localparam logic signed [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);
  localparam logic signed [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic signed [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);

  if (!(MIN_VAL < INV_VAL && INV_VAL < MAX_VAL &&
        MIN_VAL <= RST_VAL && RST_VAL <= MAX_VAL && RST_VAL != INV_VAL &&
        UP_STEP > 0 && DN_STEP > 0 &&
        MIN_VAL >= -(2 ** (WIDTH - 1)) && MAX_VAL <= (2 ** (WIDTH - 1)) - 1))
  begin : g_param_err
    $fatal(1, "param_step_counter: illegal parameter set");
  end

  function automatic logic signed [EW-1:0] widen(input logic signed [WIDTH-1:0] c);
    widen = {{2{c[WIDTH-1]}}, c};
  endfunction

  function automatic logic signed [EW-1:0] step_up(input logic signed [WIDTH-1:0] c);
    logic signed [EW-1:0] e;
    e = widen(c);
    step_up = ((e + UP_E) == INV_E) ? (e + UP2_E) : (e + UP_E);
  endfunction

  function automatic logic signed [EW-1:0] step_dn(input logic signed [WIDTH-1:0] c);
    logic signed [EW-1:0] e;
    e = widen(c);
    step_dn = ((e - DN_E) == INV_E) ? (e - DN2_E) : (e - DN_E);
  endfunction

  function automatic logic load_ok(input logic signed [WIDTH-1:0] v);
    logic signed [EW-1:0] e;
    e = widen(v);
    load_ok = (e >= MIN_E) && (e <= MAX_E) && (e != INV_E);
  endfunction

  localparam logic RST_AT_MAX = (step_up(RST_W) > MAX_E);
  localparam logic RST_AT_MIN = (step_dn(RST_W) < MIN_E);

  logic signed [WIDTH-1:0] r_cnt_p1;
  logic                    r_at_max_p1;
  logic                    r_at_min_p1;
  logic                    r_blocked_p1;
  logic                    r_load_err_p1;

  logic signed [EW-1:0]    w_up;
  logic signed [EW-1:0]    w_dn;
  logic signed [WIDTH-1:0] w_cnt_nxt;
  logic                    w_blocked_nxt;
  logic                    w_load_err_nxt;
  logic                    w_at_max_nxt;
  logic                    w_at_min_nxt;

  // Stage p0: next-state selection (load > step > hold) and look-ahead flags
  always_comb begin
    w_up           = step_up(r_cnt_p1);
    w_dn           = step_dn(r_cnt_p1);
    w_cnt_nxt      = r_cnt_p1;
    w_blocked_nxt  = 1'b0;
    w_load_err_nxt = 1'b0;
    if (bus.load) begin
      if (load_ok(bus.load_val)) begin
        w_cnt_nxt = bus.load_val;
      end else begin
        w_load_err_nxt = 1'b1;
      end
    end else if (bus.en) begin
      if (bus.mode) begin
        if (w_up > MAX_E) begin
          w_blocked_nxt = 1'b1;
`ifdef PARAM_STEP_COUNTER_WRAP_EN
          w_cnt_nxt = MIN_W;
`endif
        end else begin
          w_cnt_nxt = w_up[WIDTH-1:0];
        end
      end else begin
        if (w_dn < MIN_E) begin
          w_blocked_nxt = 1'b1;
`ifdef PARAM_STEP_COUNTER_WRAP_EN
          w_cnt_nxt = MAX_W;
`endif
        end else begin
          w_cnt_nxt = w_dn[WIDTH-1:0];
        end
      end
    end
    w_at_max_nxt = (step_up(w_cnt_nxt) > MAX_E);
    w_at_min_nxt = (step_dn(w_cnt_nxt) < MIN_E);
  end

  // Stage p1: registered counter and status
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt_p1      <= RST_W;
      r_at_max_p1   <= RST_AT_MAX;
      r_at_min_p1   <= RST_AT_MIN;
      r_blocked_p1  <= 1'b0;
      r_load_err_p1 <= 1'b0;
    end else begin
      r_cnt_p1      <= w_cnt_nxt;
      r_at_max_p1   <= w_at_max_nxt;
      r_at_min_p1   <= w_at_min_nxt;
      r_blocked_p1  <= w_blocked_nxt;
      r_load_err_p1 <= w_load_err_nxt;
    end
  end

  assign bus.cnt      = r_cnt_p1;
  assign bus.at_max   = r_at_max_p1;
  assign bus.at_min   = r_at_min_p1;
  assign bus.blocked  = r_blocked_p1;
  assign bus.load_err = r_load_err_p1;

`ifndef PARAM_STEP_COUNTER_WRAP_EN
  // MIN_W / MAX_W are only consumed by the wrap path.
  logic w_wrap_consts_unused;
  assign w_wrap_consts_unused = ^{MIN_W, MAX_W};
`endif

endmodule

// File: tb/tb_param_step_counter.sv
// Directed plus randomized bench for param_step_counter against an integer
// reference model of the counting rules.
module tb_param_step_counter;

  localparam int WIDTH = 10;
  localparam int RSTV  = 17;
  localparam int MAXV  = 269;
  localparam int MINV  = -263;
  localparam int INVV  = -47;
  localparam int UPS   = 4;
  localparam int DNS   = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  int   m_cnt = RSTV;
  bit   m_at_max = 1'b0;
  bit   m_at_min = 1'b0;
  bit   m_blocked = 1'b0;
  bit   m_load_err = 1'b0;

  param_step_counter_if #(.WIDTH(WIDTH)) bus ();

  param_step_counter #(
    .WIDTH(WIDTH), .RST_VAL(RSTV), .MAX_VAL(MAXV), .MIN_VAL(MINV),
    .INV_VAL(INVV), .UP_STEP(UPS), .DN_STEP(DNS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic int next_up(input int c);
    int v;
    v = c + UPS;
    if (v == INVV) v = c + 2 * UPS;
    return v;
  endfunction

  function automatic int next_dn(input int c);
    int v;
    v = c - DNS;
    if (v == INVV) v = c - 2 * DNS;
    return v;
  endfunction

  task automatic model(input bit r, input bit e, input bit md, input bit ld, input int lv);
    int cand;
    m_blocked  = 1'b0;
    m_load_err = 1'b0;
    if (!r) begin
      m_cnt = RSTV;
    end else if (ld) begin
      if (lv >= MINV && lv <= MAXV && lv != INVV) m_cnt = lv;
      else m_load_err = 1'b1;
    end else if (e) begin
      cand = md ? next_up(m_cnt) : next_dn(m_cnt);
      if (cand > MAXV || cand < MINV) begin
        m_blocked = 1'b1;
`ifdef PARAM_STEP_COUNTER_WRAP_EN
        m_cnt = md ? MINV : MAXV;
`endif
      end else begin
        m_cnt = cand;
      end
    end
    m_at_max = next_up(m_cnt) > MAXV;
    m_at_min = next_dn(m_cnt) < MINV;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit md, input bit ld, input int lv);
    logic signed [31:0] lv32;
    lv32         = lv;
    rst          = r;
    bus.en       = e;
    bus.mode     = md;
    bus.load     = ld;
    bus.load_val = lv32[WIDTH-1:0];
    @(posedge clk);
    #1;
    model(r, e, md, ld, lv);
    chk("cnt",      int'(bus.cnt),      m_cnt);
    chk("at_max",   int'(bus.at_max),   int'(m_at_max));
    chk("at_min",   int'(bus.at_min),   int'(m_at_min));
    chk("blocked",  int'(bus.blocked),  int'(m_blocked));
    chk("load_err", int'(bus.load_err), int'(m_load_err));
    chk("range", int'(int'(bus.cnt) >= MINV && int'(bus.cnt) <= MAXV && int'(bus.cnt) != INVV), 1);
  endtask

  initial begin
    bus.en = 1'b0; bus.mode = 1'b0; bus.load = 1'b0; bus.load_val = '0;

    // Reset, then idle
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_cnt", int'(bus.cnt), 17);
    chk("rst_flags", int'({bus.at_max, bus.at_min, bus.blocked, bus.load_err}), 0);

    // Count up to the upper bound, then one more step
    repeat (63) cyc(1, 1, 1, 0, 0);
    chk("up_top_cnt", int'(bus.cnt), 269);
    chk("up_top_at_max", int'(bus.at_max), 1);
    cyc(1, 1, 1, 0, 0);
`ifdef PARAM_STEP_COUNTER_WRAP_EN
    chk("up_over_cnt", int'(bus.cnt), -263);
`else
    chk("up_over_cnt", int'(bus.cnt), 269);
`endif
    chk("up_over_blocked", int'(bus.blocked), 1);
    cyc(1, 0, 0, 0, 0);
    chk("blocked_pulse", int'(bus.blocked), 0);

    // Forbidden-value skip in both directions
    cyc(1, 0, 0, 1, -51);
    cyc(1, 1, 1, 0, 0);
    chk("skip_up", int'(bus.cnt), -43);
    cyc(1, 0, 0, 1, -37);
    cyc(1, 1, 0, 0, 0);
    chk("skip_dn", int'(bus.cnt), -57);

    // Lower bound
    cyc(1, 0, 0, 1, -260);
    chk("near_min_at_min", int'(bus.at_min), 1);
    cyc(1, 1, 0, 0, 0);
`ifdef PARAM_STEP_COUNTER_WRAP_EN
    chk("dn_over_cnt", int'(bus.cnt), 269);
`else
    chk("dn_over_cnt", int'(bus.cnt), -260);
`endif
    chk("dn_over_blocked", int'(bus.blocked), 1);

    // Load range checking
    cyc(1, 0, 0, 1, 300);
    chk("ld300_err", int'(bus.load_err), 1);
    cyc(1, 0, 0, 1, -47);
    chk("ldinv_err", int'(bus.load_err), 1);
    cyc(1, 0, 0, 1, 0);
    chk("ld0_cnt", int'(bus.cnt), 0);
    chk("ld0_err", int'(bus.load_err), 0);

    // Priority: load over en, reset over load
    cyc(1, 1, 1, 1, 100);
    chk("load_wins", int'(bus.cnt), 100);
    cyc(0, 1, 1, 1, 50);
    chk("rst_wins", int'(bus.cnt), 17);

    // Randomized phase with biased direction bursts
    for (int blk = 0; blk < 10; blk++) begin
      bit bias;
      bias = blk[0];
      for (int i = 0; i < 40; i++) begin
        bit r, e, md, ld;
        int lv;
        r  = ($urandom_range(0, 49) != 0);
        ld = ($urandom_range(0, 5) == 0);
        e  = ($urandom_range(0, 3) != 0);
        md = ($urandom_range(0, 9) < 8) ? bias : ~bias;
        case ($urandom_range(0, 5))
          0:       lv = INVV;
          1:       lv = MAXV + int'($urandom_range(0, 3)) - 1;
          2:       lv = MINV + int'($urandom_range(0, 3)) - 2;
          default: lv = int'($urandom_range(0, 1023)) - 512;
        endcase
        cyc(r, e, md, ld, lv);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
